// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- decode / operand-fetch stage in front of the ALU.
//
// Accepts one RV32 instruction per valid/ready handshake. It decodes
// ADD/SUB/AND/OR/XOR/ADDI and reads rs1/rs2 from a 32x32 register file
// (x0 reads as zero). The register file is written by the writeback port.
// The operands, immediate, ALU function, destination and PC go into a
// single output pipeline register. That register has its own valid/ready
// handshake.
//
// Optional feature, selected by the macro RF_BYPASS_EN:
//   defined   : a writeback to rs1/rs2 in the accept cycle is forwarded into
//               the captured operand (write-through). x0 is never forwarded.
//   undefined : the captured operand is the pre-write register value.
//
// ALU function codes driven on out_func:
//   ADD=0  SUB=1  AND=2  OR=3  XOR=4  ADDI=5
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready = !out_valid || out_ready
//   in_instr, in_pc     instruction word and its PC
//   flush               drop the output slot and this cycle's accepted instr
//   wb_en/wb_rd/wb_data register file write port (writes to x0 ignored)
//   out_valid/out_ready downstream handshake
//   out_a, out_b        rs1 value; rs2 value (R-type only, else 0)
//   out_imm             sign-extended I-immediate (ADDI only, else 0)
//   out_func            ALU op code
//   out_rd, out_we      destination index and write-back request
//   out_pc              PC of the instruction
//   out_illegal         unsupported encoding (still occupies a slot)
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter bit RF_RESET_CLR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [DATA_W-1:0]     out_imm,
  output logic [3:0]            out_func,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic [31:0]           out_pc,
  output logic                  out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_ADDI = 4'd5;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  // Register file and output pipeline register
  logic [DATA_W-1:0]     r_rf [NUM_REGS];
  logic                  r_valid;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_imm;
  logic [3:0]            r_func;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_we;
  logic [31:0]           r_pc;
  logic                  r_illegal;

  // Instruction fields
  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;

  // Operand read values and decode results
  logic [DATA_W-1:0]     w_rs1_val;
  logic [DATA_W-1:0]     w_rs2_val;
  logic [DATA_W-1:0]     w_dec_a;
  logic [DATA_W-1:0]     w_dec_b;
  logic [DATA_W-1:0]     w_dec_imm;
  logic [3:0]            w_dec_func;
  logic [REG_ADDR_W-1:0] w_dec_rd;
  logic                  w_dec_we;
  logic                  w_dec_illegal;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_wb_hit;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_f3     = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_f7     = in_instr[31:25];

  // The stage is ready while reset is asserted so upstream never sees a
  // stall caused by a stale output slot.
  assign w_in_ready = !rst_n || !r_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_wb_hit   = wb_en && (wb_rd != {REG_ADDR_W{1'b0}});

  // Register file: optional clear on reset, otherwise the writeback port
  always_ff @(posedge clk) begin
    if (!rst_n && RF_RESET_CLR) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wb_hit) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // rs1 read: x0 is hard zero, optional same-cycle writeback forwarding
  always_comb begin
    w_rs1_val = {DATA_W{1'b0}};
    if (w_rs1 == {REG_ADDR_W{1'b0}}) begin
      w_rs1_val = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
    end else if (w_wb_hit && (wb_rd == w_rs1)) begin
      w_rs1_val = wb_data;
`endif
    end else begin
      w_rs1_val = r_rf[w_rs1];
    end
  end

  // rs2 read: x0 is hard zero, optional same-cycle writeback forwarding
  always_comb begin
    w_rs2_val = {DATA_W{1'b0}};
    if (w_rs2 == {REG_ADDR_W{1'b0}}) begin
      w_rs2_val = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
    end else if (w_wb_hit && (wb_rd == w_rs2)) begin
      w_rs2_val = wb_data;
`endif
    end else begin
      w_rs2_val = r_rf[w_rs2];
    end
  end

  // Decode: defaults describe the illegal-instruction result
  always_comb begin
    w_dec_a       = {DATA_W{1'b0}};
    w_dec_b       = {DATA_W{1'b0}};
    w_dec_imm     = {DATA_W{1'b0}};
    w_dec_func    = ALU_ADD;
    w_dec_rd      = {REG_ADDR_W{1'b0}};
    w_dec_we      = 1'b0;
    w_dec_illegal = 1'b1;
    case (w_opcode)
      OP_REG: begin
        // R-type: only f7 = 0 forms, plus SUB with f7 = 0100000
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000: begin w_dec_func = ALU_ADD; w_dec_illegal = 1'b0; end
            3'b111: begin w_dec_func = ALU_AND; w_dec_illegal = 1'b0; end
            3'b110: begin w_dec_func = ALU_OR;  w_dec_illegal = 1'b0; end
            3'b100: begin w_dec_func = ALU_XOR; w_dec_illegal = 1'b0; end
            default: begin w_dec_func = ALU_ADD; w_dec_illegal = 1'b1; end
          endcase
        end else if ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)) begin
          w_dec_func    = ALU_SUB;
          w_dec_illegal = 1'b0;
        end else begin
          w_dec_func    = ALU_ADD;
          w_dec_illegal = 1'b1;
        end
        if (!w_dec_illegal) begin
          w_dec_a  = w_rs1_val;
          w_dec_b  = w_rs2_val;
          w_dec_rd = w_rd;
          w_dec_we = 1'b1;
        end else begin
          w_dec_func = ALU_ADD;
        end
      end
      OP_IMM: begin
        if (w_f3 == 3'b000) begin
          w_dec_func    = ALU_ADDI;
          w_dec_illegal = 1'b0;
          w_dec_a       = w_rs1_val;
          w_dec_imm     = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
          w_dec_rd      = w_rd;
          w_dec_we      = 1'b1;
        end else begin
          w_dec_func    = ALU_ADD;
          w_dec_illegal = 1'b1;
        end
      end
      default: begin
        w_dec_func    = ALU_ADD;
        w_dec_illegal = 1'b1;
      end
    endcase
  end

  // Output pipeline register; flush beats accept, accept beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= {DATA_W{1'b0}};
      r_b       <= {DATA_W{1'b0}};
      r_imm     <= {DATA_W{1'b0}};
      r_func    <= 4'd0;
      r_rd      <= {REG_ADDR_W{1'b0}};
      r_we      <= 1'b0;
      r_pc      <= 32'd0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_a       <= w_dec_a;
      r_b       <= w_dec_b;
      r_imm     <= w_dec_imm;
      r_func    <= w_dec_func;
      r_rd      <= w_dec_rd;
      r_we      <= w_dec_we;
      r_pc      <= in_pc;
      r_illegal <= w_dec_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_valid;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign out_imm     = r_imm;
  assign out_func    = r_func;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed and randomised stimulus for id_stage.
// A transaction-level model (mask-based decoder, array register file,
// single-slot output) predicts the outputs. These are compared on every
// falling edge. Directed steps also pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_ADDI = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, wb_data, out_a, out_b, out_imm, out_pc;
  logic [4:0]  wb_rd, out_rd;
  logic [3:0]  out_func;
  logic        out_we, out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] a, b, imm, pc;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  // model state
  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;
  logic        m_init  = 1'b0;
  exp_t        m_out;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_func(out_func),
    .out_rd(out_rd), .out_we(out_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // register value as seen in the accept cycle
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  // mask-match decoder working on whole instruction words
  function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] rm;
    logic [31:0] va, vb;
    e    = '0;
    e.pc = pc;
    rm   = ins & 32'hFE00707F;
    va   = m_read(ins[19:15]);
    vb   = m_read(ins[24:20]);
    e.ill = 1'b0;
    if      (rm == 32'h00000033) e.func = F_ADD;
    else if (rm == 32'h40000033) e.func = F_SUB;
    else if (rm == 32'h00007033) e.func = F_AND;
    else if (rm == 32'h00006033) e.func = F_OR;
    else if (rm == 32'h00004033) e.func = F_XOR;
    else if ((ins & 32'h0000707F) == 32'h00000013) e.func = F_ADDI;
    else e.ill = 1'b1;
    if (e.ill) begin
      e.func = F_ADD;
    end else begin
      e.we = 1'b1;
      e.rd = ins[11:7];
      e.a  = va;
      if (e.func == F_ADDI) e.imm = {{20{ins[31]}}, ins[31:20]};
      else                  e.b   = vb;
    end
    return e;
  endfunction

  // model advances on each rising edge from the bench-driven inputs
  always @(posedge clk) begin
    logic acc;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_out   = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_init  = 1'b1;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_out   = m_decode(in_instr, in_pc);
      end else if (out_ready) m_valid = 1'b0;
      if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    end
  end

  // compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!rst_n || !m_valid || out_ready)});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("m_out_a", out_a, m_out.a);
        chk("m_out_b", out_b, m_out.b);
        chk("m_out_imm", out_imm, m_out.imm);
        chk("m_out_func", {28'd0, out_func}, {28'd0, m_out.func});
        chk("m_out_we", {31'd0, out_we}, {31'd0, m_out.we});
        chk("m_out_ill", {31'd0, out_illegal}, {31'd0, m_out.ill});
        chk("m_out_pc", out_pc, m_out.pc);
        if (!m_out.ill) chk("m_out_rd", {27'd0, out_rd}, {27'd0, m_out.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_ops(input string n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [3:0] f, input logic [4:0] rd);
    chk({n, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({n, "_a"}, out_a, a);
    chk({n, "_b"}, out_b, b);
    chk({n, "_imm"}, out_imm, imm);
    chk({n, "_func"}, {28'd0, out_func}, {28'd0, f});
    chk({n, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;

    // 1: reset state
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_a", out_a, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_misc", {out_func, out_rd, out_we, out_illegal}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // 2/3: sub then addi back to back
    wb(5'd5, 32'd7);
    wb(5'd6, 32'd3);
    in_valid = 1'b1; in_instr = 32'h406283B3; in_pc = 32'h0000_0100;
    tick();
    chk_ops("sub", 32'd7, 32'd3, 32'd0, F_SUB, 5'd7);
    chk("sub_we", {31'd0, out_we}, 32'd1);
    chk("sub_pc", out_pc, 32'h0000_0100);
    in_instr = 32'hFFF00093; in_pc = 32'h0000_0104;
    tick();
    in_valid = 1'b0;
    chk_ops("addi", 32'd0, 32'd0, 32'hFFFF_FFFF, F_ADDI, 5'd1);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // 4: backpressure holds outputs, then the waiting instr is taken
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(7'd0, 5'd6, 5'd5, 3'b000, 5'd8); in_pc = 32'h200;
    tick();
    in_instr = rtype(7'd0, 5'd6, 5'd5, 3'b100, 5'd9); in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk_ops("stall", 32'd7, 32'd3, 32'd0, F_ADD, 5'd8);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_ops("xor", 32'd7, 32'd3, 32'd0, F_XOR, 5'd9);
    chk("xor_pc", out_pc, 32'h204);
    tick();
    chk("xor_once", {31'd0, out_valid}, 32'd0);

    // 5: illegal, x0 write ignored, flush
    issue(32'h0000_0000, 32'h300);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_we", {31'd0, out_we}, 32'd0);
    chk("ill_ops", out_a | out_b | out_imm | {28'd0, out_func}, 32'd0);
    wb(5'd0, 32'h55);
    issue(rtype(7'd0, 5'd6, 5'd0, 3'b110, 5'd10), 32'h304);
    chk_ops("x0_or", 32'd0, 32'd3, 32'd0, F_OR, 5'd10);
    flush = 1'b1;
    issue(rtype(7'd0, 5'd6, 5'd5, 3'b111, 5'd11), 32'h308);
    flush = 1'b0;
    chk("flush_accept", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    issue(rtype(7'd0, 5'd6, 5'd5, 3'b111, 5'd11), 32'h30C);
    chk_ops("and", 32'd7, 32'd3, 32'd0, F_AND, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_held", {31'd0, out_valid}, 32'd0);

    // 6: same-cycle write and read of x5
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd9;
    issue(rtype(7'd0, 5'd0, 5'd5, 3'b000, 5'd7), 32'h400);
    wb_en = 1'b0;
`ifdef RF_BYPASS_EN
    chk("hazard_a", out_a, 32'd9);
`else
    chk("hazard_a", out_a, 32'd7);
`endif
    issue(rtype(7'd0, 5'd0, 5'd5, 3'b000, 5'd7), 32'h404);
    chk("after_wb_a", out_a, 32'd9);

    // randomised traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: ins = rtype(7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom));
        1: ins = rtype(7'b0100000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom));
        2: ins = rtype(7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b111, 5'($urandom));
        3: ins = rtype(7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b110, 5'($urandom));
        4: ins = rtype(7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b100, 5'($urandom));
        5: ins = itype(12'($urandom), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom));
        6: ins = rtype(7'b0100000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b111, 5'd3);
        default: ins = $urandom;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = ins;
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      tick();
    end
    flush = 1'b0; wb_en = 1'b0; out_ready = 1'b0;

    // reset with traffic pending clears output and register file
    in_valid = 1'b1; in_instr = rtype(7'd0, 5'd6, 5'd5, 3'b000, 5'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    issue(rtype(7'd0, 5'd6, 5'd5, 3'b000, 5'd1), 32'h500);
    chk("rf_cleared_a", out_a, 32'd0);
    chk("rf_cleared_b", out_b, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
